board_io_bridge: RTL and testbench

BOARD_IO_BRIDGE -- requirements
Module: board_io_bridge

---
 rtl/board_io_bridge.sv | 188 ++++++++++++++++++
 tb/tb_board_io_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_bridge.sv
// Board-level I/O bridge: synchronises and debounces board inputs, generates the
// core clock-enable and stretched core reset, and drives debug LEDs and the PDM pin.
module board_io_bridge #(
    parameter int CLK_DIV    = 2,
    parameter int DEB_CYCLES = 16,
    parameter int RST_HOLD   = 16,
    parameter int N_LED      = 4,
    parameter int HB_BITS    = 24,
    parameter int PDM_BIT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       btn_raw,
    input  logic [3:0]       sw_raw,
    input  logic             spi_clk_raw,
    input  logic             spi_cs_n_raw,
    input  logic             spi_mosi_raw,
    input  logic [7:0]       core_uo,
    output logic             core_ce,
    output logic             core_rst_n,
    output logic             core_ena,
    output logic [7:0]       core_ui,
    output logic             pdm_out,
    output logic [N_LED-1:0] led
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD - 1);
    localparam logic [7:0]    DIV_MAX  = 8'(CLK_DIV - 1);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Sync vector layout: [3:0] btn, [7:4] sw, [8] spi clk, [9] cs_n (idles high), [10] mosi
    localparam logic [10:0] SYNC_RST = 11'b010_0000_0000;

    logic [10:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [7:0]          db_q, db_d;
    logic [7:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [7:0]          div_q, div_d;
    logic                ce_q, ce_d;
    logic [1:0]          st_q, st_d;
    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic                rst_n_q, rst_n_d;
    logic                cs_prev_q, cs_prev_d;
    logic [3:0]          act_q, act_d;
    logic [HB_BITS:0]    hb_q, hb_d;
    logic                pdm_q, pdm_d;
    logic [N_LED-1:0]    led_q, led_d;
    logic [3:0]          led_src_s;
    logic                btn0_db_s;
    logic                cs_n_s;

    assign btn0_db_s = db_q[0];
    assign cs_n_s    = sync2_q[9];

    always_comb begin
        sync1_d = {spi_mosi_raw, spi_cs_n_raw, spi_clk_raw, sw_raw, btn_raw};
        sync2_d = sync1_q;
    end

    // A debouncer adopts the synced value only after it has differed for DEB_CYCLES cycles.
    always_comb begin
        db_d      = db_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 8; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_MAX) begin
                db_d[i]      = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    // core_ce is registered from the next divider value so it matches div_q == CLK_DIV-1.
    always_comb begin
        div_d = (div_q == DIV_MAX) ? 8'd0 : div_q + 8'd1;
        ce_d  = (div_d == DIV_MAX);
    end

    always_comb begin
        st_d   = st_q;
        hcnt_d = hcnt_q;
        case (st_q)
            ST_HOLD: begin
                hcnt_d = '0;
                if (!btn0_db_s) begin
                    st_d = ST_COUNT;
                end else begin
                    st_d = ST_HOLD;
                end
            end
            ST_COUNT: begin
                if (btn0_db_s) begin
                    st_d   = ST_HOLD;
                    hcnt_d = '0;
                end else if (hcnt_q == HOLD_MAX) begin
                    st_d = ST_RUN;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            ST_RUN: begin
                if (btn0_db_s) begin
                    st_d = ST_HOLD;
                end else begin
                    st_d = ST_RUN;
                end
            end
            default: begin
                st_d   = ST_HOLD;
                hcnt_d = '0;
            end
        endcase
        rst_n_d = (st_d == ST_RUN);
    end

    always_comb begin
        cs_prev_d = cs_n_s;
        if (cs_prev_q && !cs_n_s) begin
            act_d = act_q + 4'd1;
        end else begin
            act_d = act_q;
        end
        hb_d  = hb_q + (HB_BITS+1)'(1);
        pdm_d = core_uo[PDM_BIT];
    end

    always_comb begin
        case ({db_q[6], db_q[5]})
            2'b00:   led_src_s = core_uo[3:0];
            2'b01:   led_src_s = {3'b000, hb_q[HB_BITS]};
            2'b10:   led_src_s = act_q;
            2'b11:   led_src_s = core_uo[7:4];
            default: led_src_s = 4'h0;
        endcase
        led_d = led_src_s[N_LED-1:0];
    end

    // All state registers; rst forces the idle values immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= SYNC_RST;
            sync2_q   <= SYNC_RST;
            db_q      <= 8'h00;
            deb_cnt_q <= '0;
            div_q     <= 8'd0;
            ce_q      <= 1'b0;
            st_q      <= ST_HOLD;
            hcnt_q    <= '0;
            rst_n_q   <= 1'b0;
            cs_prev_q <= 1'b1;
            act_q     <= 4'd0;
            hb_q      <= '0;
            pdm_q     <= 1'b0;
            led_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            deb_cnt_q <= deb_cnt_d;
            div_q     <= div_d;
            ce_q      <= ce_d;
            st_q      <= st_d;
            hcnt_q    <= hcnt_d;
            rst_n_q   <= rst_n_d;
            cs_prev_q <= cs_prev_d;
            act_q     <= act_d;
            hb_q      <= hb_d;
            pdm_q     <= pdm_d;
            led_q     <= led_d;
        end
    end

    assign core_ce    = ce_q;
    assign core_rst_n = rst_n_q;
    assign core_ena   = db_q[4];
    assign core_ui    = {5'b00000, sync2_q[10], sync2_q[9], sync2_q[8]};
    assign pdm_out    = pdm_q;
    assign led        = led_q;

endmodule

// File: tb/tb_board_io_bridge.sv
// Directed testbench for board_io_bridge: main instance with CLK_DIV=3, DEB_CYCLES=4,
// HB_BITS=3, plus a CLK_DIV=1 instance sharing the same inputs.
module tb_board_io_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'h0;
    logic [3:0] sw_raw = 4'h0;
    logic       spi_clk_raw = 1'b0;
    logic       spi_cs_n_raw = 1'b1;
    logic       spi_mosi_raw = 1'b0;
    logic [7:0] core_uo = 8'h00;

    logic       core_ce, core_rst_n, core_ena, pdm_out;
    logic [7:0] core_ui;
    logic [3:0] led;
    logic       ce1, rst_n1, ena1, pdm1;
    logic [7:0] ui1;
    logic [3:0] led1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    board_io_bridge #(.CLK_DIV(3), .DEB_CYCLES(4), .RST_HOLD(16), .N_LED(4),
                      .HB_BITS(3), .PDM_BIT(1)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .spi_clk_raw(spi_clk_raw), .spi_cs_n_raw(spi_cs_n_raw), .spi_mosi_raw(spi_mosi_raw),
        .core_uo(core_uo), .core_ce(core_ce), .core_rst_n(core_rst_n), .core_ena(core_ena),
        .core_ui(core_ui), .pdm_out(pdm_out), .led(led)
    );

    board_io_bridge #(.CLK_DIV(1)) dut_div1 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .spi_clk_raw(spi_clk_raw), .spi_cs_n_raw(spi_cs_n_raw), .spi_mosi_raw(spi_mosi_raw),
        .core_uo(core_uo), .core_ce(ce1), .core_rst_n(rst_n1), .core_ena(ena1),
        .core_ui(ui1), .pdm_out(pdm1), .led(led1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        spi_clk_raw = 1'b1; spi_mosi_raw = 1'b1; spi_cs_n_raw = 1'b0; core_uo = 8'hFF;
        repeat (3) tick();
        total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL reset_rst_n: got %b want 0", core_rst_n); end
        total++; if (core_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", core_ce); end
        total++; if (ce1 !== 1'b0) begin bad++; $display("FAIL reset_ce_div1: got %b want 0", ce1); end
        total++; if (core_ena !== 1'b0) begin bad++; $display("FAIL reset_ena: got %b want 0", core_ena); end
        total++; if (pdm_out !== 1'b0) begin bad++; $display("FAIL reset_pdm: got %b want 0", pdm_out); end
        total++; if (core_ui !== 8'h02) begin bad++; $display("FAIL reset_ui: got %h want 02", core_ui); end
        total++; if (led !== 4'h0) begin bad++; $display("FAIL reset_led: got %h want 0", led); end
        spi_clk_raw = 1'b0; spi_mosi_raw = 1'b0; spi_cs_n_raw = 1'b1; core_uo = 8'h00;
        tick();
    endtask

    // Caller has just released rst; the next edge moves the FSM out of HOLD.
    task automatic run_stretch(input string name);
        logic exp;
        for (int t = 1; t <= 17; t++) begin
            tick();
            exp = (t == 17);
            total++;
            if (core_rst_n !== exp) begin
                bad++; $display("FAIL %s cycle %0d: got %b want %b", name, t, core_rst_n, exp);
            end
        end
    endtask

    task automatic test_stretch;
        rst = 1'b0;
        run_stretch("stretch");
    endtask

    task automatic test_core_ui;
        spi_clk_raw = 1'b1; spi_mosi_raw = 1'b1;
        tick();
        total++; if (core_ui !== 8'h02) begin bad++; $display("FAIL ui_early: got %h want 02", core_ui); end
        tick();
        total++; if (core_ui !== 8'h07) begin bad++; $display("FAIL ui_sync: got %h want 07", core_ui); end
        spi_clk_raw = 1'b0; spi_mosi_raw = 1'b0;
        repeat (2) tick();
        total++; if (core_ui !== 8'h02) begin bad++; $display("FAIL ui_back: got %h want 02", core_ui); end
    endtask

    task automatic test_led_uo;
        core_uo = 8'h5A;
        tick();
        total++; if (led !== 4'hA) begin bad++; $display("FAIL led_uo_5a: got %h want a", led); end
        total++; if (pdm_out !== 1'b1) begin bad++; $display("FAIL pdm_5a: got %b want 1", pdm_out); end
        core_uo = 8'hA5;
        #2;
        total++; if (pdm_out !== 1'b1) begin bad++; $display("FAIL pdm_latency: got %b want 1", pdm_out); end
        tick();
        total++; if (led !== 4'h5) begin bad++; $display("FAIL led_uo_low: got %h want 5", led); end
        total++; if (pdm_out !== 1'b0) begin bad++; $display("FAIL pdm_a5: got %b want 0", pdm_out); end
        sw_raw = 4'b0111;
        repeat (10) tick();
        total++; if (led !== 4'hA) begin bad++; $display("FAIL led_uo_high: got %h want a", led); end
        total++; if (core_ena !== 1'b1) begin bad++; $display("FAIL ena_on: got %b want 1", core_ena); end
        sw_raw = 4'b0000;
        repeat (10) tick();
        total++; if (core_ena !== 1'b0) begin bad++; $display("FAIL ena_off: got %b want 0", core_ena); end
    endtask

    task automatic test_debounce;
        logic exp;
        btn_raw = 4'b0001;
        repeat (3) tick();
        btn_raw = 4'b0000;
        for (int t = 1; t <= 12; t++) begin
            tick();
            total++;
            if (core_rst_n !== 1'b1) begin bad++; $display("FAIL glitch cycle %0d: got %b want 1", t, core_rst_n); end
        end
        btn_raw = 4'b0001;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t == 6) btn_raw = 4'b0000;
            exp = !(t >= 7 && t <= 28);
            total++;
            if (core_rst_n !== exp) begin
                bad++; $display("FAIL long_press cycle %0d: got %b want %b", t, core_rst_n, exp);
            end
        end
    endtask

    task automatic test_activity;
        sw_raw = 4'b0100;
        repeat (10) tick();
        total++; if (led !== 4'h0) begin bad++; $display("FAIL act_start: got %h want 0", led); end
        for (int k = 1; k <= 17; k++) begin
            spi_cs_n_raw = 1'b0;
            repeat (2) tick();
            spi_cs_n_raw = 1'b1;
            repeat (2) tick();
            if (k == 1) begin
                total++; if (led !== 4'h1) begin bad++; $display("FAIL act_1: got %h want 1", led); end
            end else if (k == 15) begin
                total++; if (led !== 4'hF) begin bad++; $display("FAIL act_15: got %h want f", led); end
            end else if (k == 16) begin
                total++; if (led !== 4'h0) begin bad++; $display("FAIL act_wrap: got %h want 0", led); end
            end else if (k == 17) begin
                total++; if (led !== 4'h1) begin bad++; $display("FAIL act_17: got %h want 1", led); end
            end
        end
    endtask

    task automatic test_heartbeat;
        logic v, exp;
        int n;
        sw_raw = 4'b0010;
        repeat (10) tick();
        v = led[0];
        n = 0;
        while (led[0] === v && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n >= 20) begin bad++; $display("FAIL hb_toggle: got no toggle in %0d cycles want toggle", n); end
        v = led[0];
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = (i == 8) ? ~v : v;
            total++;
            if (led !== {3'b000, exp}) begin bad++; $display("FAIL hb_period cycle %0d: got %h want %h", i, led, {3'b000, exp}); end
        end
    endtask

    task automatic test_clkdiv;
        logic exp;
        int n;
        n = 0;
        while (core_ce !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (n >= 10) begin bad++; $display("FAIL ce_seen: got no pulse in %0d cycles want pulse", n); end
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = ((i % 3) == 0);
            total++;
            if (core_ce !== exp) begin bad++; $display("FAIL ce_div3 cycle %0d: got %b want %b", i, core_ce, exp); end
            total++;
            if (ce1 !== 1'b1) begin bad++; $display("FAIL ce_div1 cycle %0d: got %b want 1", i, ce1); end
        end
    endtask

    task automatic test_async_reset;
        sw_raw = 4'b0001; core_uo = 8'hA7;
        spi_clk_raw = 1'b1; spi_mosi_raw = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        total++; if (core_ena !== 1'b1) begin bad++; $display("FAIL pre_ena: got %b want 1", core_ena); end
        total++; if (led !== 4'h7) begin bad++; $display("FAIL pre_led: got %h want 7", led); end
        total++; if (core_ui !== 8'h07) begin bad++; $display("FAIL pre_ui: got %h want 07", core_ui); end
        total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL pre_count: got %b want 0", core_rst_n); end
        #3;
        rst = 1'b1;
        #1;
        total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL async_rst_n: got %b want 0", core_rst_n); end
        total++; if (core_ce !== 1'b0) begin bad++; $display("FAIL async_ce: got %b want 0", core_ce); end
        total++; if (ce1 !== 1'b0) begin bad++; $display("FAIL async_ce_div1: got %b want 0", ce1); end
        total++; if (core_ena !== 1'b0) begin bad++; $display("FAIL async_ena: got %b want 0", core_ena); end
        total++; if (pdm_out !== 1'b0) begin bad++; $display("FAIL async_pdm: got %b want 0", pdm_out); end
        total++; if (core_ui !== 8'h02) begin bad++; $display("FAIL async_ui: got %h want 02", core_ui); end
        total++; if (led !== 4'h0) begin bad++; $display("FAIL async_led: got %h want 0", led); end
        tick();
        rst = 1'b0;
        run_stretch("restretch");
    endtask

    initial begin
        test_reset();
        test_stretch();
        test_core_ui();
        test_led_uo();
        test_debounce();
        test_activity();
        test_heartbeat();
        test_clkdiv();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule
